// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encoding and bit-timing helper, common to uart_rx and uart_tx.
package uart_rx_pkg;

    typedef logic [2:0] uart_state_t;

    localparam uart_state_t ST_IDLE  = 3'd0;
    localparam uart_state_t ST_START = 3'd1;
    localparam uart_state_t ST_DATA  = 3'd2;
    localparam uart_state_t ST_STOP  = 3'd3;
    localparam uart_state_t ST_BREAK = 3'd4;

    // Clock cycles per bit period, truncated; clkFreqMhz is in MHz.
    function automatic int clks_per_bit(input int clkFreqMhz, input int baud);
        return (clkFreqMhz * 1000000) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit, with a configurable reset value.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronised, majority-voted mid-bit sampling, valid/ready output buffer
// with registered framing-error and overrun pulses.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int CLK_FREQ = 27,
    parameter int BAUD     = 115200
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int CPB   = clks_per_bit(CLK_FREQ, BAUD);
    localparam int HALF  = CPB / 2;
    localparam int CNT_W = $clog2(CPB);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CPB - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             rxSync;
    logic [2:0]       samp_q;
    logic             vote;

    uart_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       shreg_q, shreg_d;
    logic             deliver_q, deliver_d;
    logic             frameErr_q, frameErr_d;

    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             overrun_q, overrun_d;

    sync_2ff #(
        .RESET_VAL(1'b1)
    ) u_sync (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .d_i   (rx_i),
        .q_o   (rxSync)
    );

    // Two of the last three synced samples must agree, so a single-cycle glitch never wins.
    assign vote = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            samp_q <= 3'b111;
        end else begin
            samp_q <= {samp_q[1:0], rxSync};
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bitIdx_d   = bitIdx_q;
        shreg_d    = shreg_q;
        deliver_d  = 1'b0;
        frameErr_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (!rxSync) begin
                    state_d = ST_START;
                end
            end

            // Spending HALF cycles here puts every later sample point at mid-bit.
            ST_START: begin
                if (cnt_q == CNT_HALF) begin
                    cnt_d    = '0;
                    bitIdx_d = 3'd0;
                    state_d  = vote ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {vote, shreg_q[7:1]};
                    if (bitIdx_q == 3'd7) begin
                        state_d = ST_STOP;
                    end else begin
                        bitIdx_d = bitIdx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (vote) begin
                        deliver_d = 1'b1;
                        state_d   = ST_IDLE;
                    end else begin
                        frameErr_d = 1'b1;
                        state_d    = ST_BREAK;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            // A line held low after a bad stop bit must not look like a fresh start bit.
            ST_BREAK: begin
                cnt_d = '0;
                if (rxSync) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            bitIdx_q   <= 3'd0;
            shreg_q    <= 8'h00;
            deliver_q  <= 1'b0;
            frameErr_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bitIdx_q   <= bitIdx_d;
            shreg_q    <= shreg_d;
            deliver_q  <= deliver_d;
            frameErr_q <= frameErr_d;
        end
    end

    // A consume and a delivery in the same cycle keep valid high with the new byte.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        if (deliver_q) begin
            if (!valid_q || ready_i) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            data_q    <= data_d;
            valid_q   <= valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = frameErr_q;
    assign overrun_o   = overrun_q;

endmodule
